// File: rtl/pipe_reg_pkg.sv
// Shared pipeline-register types: IF/ID contents plus the fetch-stage state encoding.
package pipe_reg_pkg;

    localparam int IF_PC_W    = 9;
    localparam int IF_INSTR_W = 32;
    localparam int PC_INC     = 4;

    typedef struct packed {
        logic [IF_PC_W-1:0]    current;
        logic [IF_PC_W-1:0]    pc_next;
        logic [IF_INSTR_W-1:0] instr;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
    } if_id_reg_t;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_pc_gen.sv
// PC register for the fetch stage: redirect (word-aligned) beats stall beats +4 advance.
module pc_gen
    import pipe_reg_pkg::*;
#(
    parameter int             PC_W     = IF_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_plus4_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Adder wraps naturally at 2^PC_W.
    assign pc_plus4_o = pc_q + PC_W'(PC_INC);
    assign pc_o       = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i & ~PC_W'(3);
        end else if (!stall_i) begin
            pc_d = pc_plus4_o;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: drives a 1-cycle synchronous ROM and fills the IF/ID register,
// inserting bubbles for wrong-path and not-yet-returned fetches.
module if_fetch_stage
    import pipe_reg_pkg::*;
#(
    parameter int              PC_W     = IF_PC_W,
    parameter int              INSTR_W  = IF_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = 9'h000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               imem_en_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output if_id_reg_t         if_id_o,
    output logic               if_id_valid_o,
    output fetch_state_e       state_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_plus4;

    // req_* describe the fetch whose data is on imem_rdata_i this cycle.
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic [PC_W-1:0] req_next_q, req_next_d;
    logic            req_vld_q, req_vld_d;
    if_id_reg_t      if_id_q, if_id_d;
    logic            valid_q, valid_d;
    fetch_state_e    state_q, state_d;

    pc_gen #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc_q),
        .pc_plus4_o    (pc_plus4)
    );

    // A stalled ROM keeps its output, so the pending fetch survives the stall.
    assign imem_en_o     = ~stall_i | redirect_i;
    assign imem_addr_o   = pc_q;
    assign if_id_o       = if_id_q;
    assign if_id_valid_o = valid_q;
    assign state_o       = state_q;

    always_comb begin
        req_pc_d   = req_pc_q;
        req_next_d = req_next_q;
        req_vld_d  = req_vld_q;
        if_id_d    = if_id_q;
        valid_d    = valid_q;
        state_d    = state_q;
        if (redirect_i) begin
            req_vld_d = 1'b0;
            if_id_d   = '0;
            valid_d   = 1'b0;
            state_d   = BUBBLE;
        end else if (!stall_i) begin
            req_pc_d   = pc_q;
            req_next_d = pc_plus4;
            req_vld_d  = 1'b1;
            state_d    = RUN;
            if (req_vld_q && state_q == RUN) begin
                if_id_d.current = req_pc_q;
                if_id_d.pc_next = req_next_q;
                if_id_d.instr   = imem_rdata_i;
                if_id_d.rs1     = imem_rdata_i[19:15];
                if_id_d.rs2     = imem_rdata_i[24:20];
                valid_d         = 1'b1;
            end else begin
                if_id_d = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_pc_q   <= '0;
            req_next_q <= '0;
            req_vld_q  <= 1'b0;
            if_id_q    <= '0;
            valid_q    <= 1'b0;
            state_q    <= FILL;
        end else begin
            req_pc_q   <= req_pc_d;
            req_next_q <= req_next_d;
            req_vld_q  <= req_vld_d;
            if_id_q    <= if_id_d;
            valid_q    <= valid_d;
            state_q    <= state_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a synchronous ROM model holding 0x00100093+word_index.
module tb_if_fetch_stage;
    import pipe_reg_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         stall_i;
    logic         redirect_i;
    logic [8:0]   redirect_pc_i;
    logic         imem_en_o;
    logic [8:0]   imem_addr_o;
    logic [31:0]  imem_rdata_i;
    if_id_reg_t   if_id_o;
    logic         if_id_valid_o;
    fetch_state_e state_o;

    int vectors;
    int miscompares;

    if_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_en_o     (imem_en_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .if_id_o       (if_id_o),
        .if_id_valid_o (if_id_valid_o),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [8:0] addr);
        return 32'h0010_0093 + 32'(addr >> 2);
    endfunction

    always @(posedge clk) begin
        if (imem_en_o) imem_rdata_i <= rom_word(imem_addr_o);
    end

    function automatic if_id_reg_t exp_entry(input logic [8:0] c);
        if_id_reg_t  e;
        logic [31:0] w;
        w         = rom_word(c);
        e.current = c;
        e.pc_next = c + 9'd4;
        e.instr   = w;
        e.rs1     = w[19:15];
        e.rs2     = w[24:20];
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        step();
        step();
        vectors++;
        if (if_id_valid_o !== 1'b0 || if_id_o !== '0 || imem_en_o !== 1'b1 ||
            imem_addr_o !== 9'h000 || state_o !== FILL) begin
            miscompares++;
            $display("FAIL reset: got valid=%b if_id=%h en=%b addr=%h state=%0d, want 0 0 1 000 FILL",
                     if_id_valid_o, if_id_o, imem_en_o, imem_addr_o, state_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [8:0] c;
        step();
        vectors++;
        if (if_id_valid_o !== 1'b0 || if_id_o !== '0 || imem_addr_o !== 9'h004) begin
            miscompares++;
            $display("FAIL fill_first_edge: got valid=%b if_id=%h addr=%h, want 0 0 004",
                     if_id_valid_o, if_id_o, imem_addr_o);
        end
        for (int i = 0; i < 3; i++) begin
            c = 9'(i * 4);
            step();
            vectors++;
            if (if_id_valid_o !== 1'b1 || if_id_o !== exp_entry(c)) begin
                miscompares++;
                $display("FAIL fill_current_%h: got valid=%b if_id=%h, want 1 %h",
                         c, if_id_valid_o, if_id_o, exp_entry(c));
            end
        end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        #1;
        vectors++;
        if (imem_en_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_en: got imem_en=%b, want 0", imem_en_o);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (if_id_valid_o !== 1'b1 || if_id_o !== exp_entry(9'h008) || imem_addr_o !== 9'h010) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got valid=%b if_id=%h addr=%h, want 1 %h 010",
                         i, if_id_valid_o, if_id_o, imem_addr_o, exp_entry(9'h008));
            end
        end
        stall_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (if_id_valid_o !== 1'b1 || if_id_o !== exp_entry(9'(12 + i * 4))) begin
                miscompares++;
                $display("FAIL stall_release_%0d: got valid=%b if_id=%h, want 1 %h",
                         i, if_id_valid_o, if_id_o, exp_entry(9'(12 + i * 4)));
            end
        end
    endtask

    task automatic test_redirect(input logic [8:0] target, input logic [8:0] aligned,
                                 input logic with_stall);
        redirect_i = 1'b1; redirect_pc_i = target; stall_i = with_stall;
        #1;
        vectors++;
        if (imem_en_o !== 1'b1) begin
            miscompares++;
            $display("FAIL redirect_en_%h: got imem_en=%b, want 1", target, imem_en_o);
        end
        step();
        redirect_i = 1'b0; stall_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (if_id_valid_o !== 1'b0 || if_id_o !== '0 || imem_addr_o !== aligned + 9'(i * 4)) begin
                miscompares++;
                $display("FAIL redirect_bubble_%h_%0d: got valid=%b if_id=%h addr=%h, want 0 0 %h",
                         target, i, if_id_valid_o, if_id_o, imem_addr_o, aligned + 9'(i * 4));
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (if_id_valid_o !== 1'b1 || if_id_o !== exp_entry(aligned + 9'(i * 4))) begin
                miscompares++;
                $display("FAIL redirect_target_%h_%0d: got valid=%b if_id=%h, want 1 %h",
                         target, i, if_id_valid_o, if_id_o, exp_entry(aligned + 9'(i * 4)));
            end
            if (i == 0) step();
        end
    endtask

    task automatic test_back_to_back();
        redirect_i = 1'b1; redirect_pc_i = 9'h100;
        step();
        vectors++;
        if (if_id_valid_o !== 1'b0 || imem_addr_o !== 9'h100 || state_o !== BUBBLE) begin
            miscompares++;
            $display("FAIL b2b_first: got valid=%b addr=%h state=%0d, want 0 100 BUBBLE",
                     if_id_valid_o, imem_addr_o, state_o);
        end
        redirect_pc_i = 9'h120;
        step();
        redirect_i = 1'b0;
        vectors++;
        if (if_id_valid_o !== 1'b0 || if_id_o !== '0 || imem_addr_o !== 9'h120) begin
            miscompares++;
            $display("FAIL b2b_second: got valid=%b if_id=%h addr=%h, want 0 0 120",
                     if_id_valid_o, if_id_o, imem_addr_o);
        end
        step();
        step();
        vectors++;
        if (if_id_valid_o !== 1'b1 || if_id_o !== exp_entry(9'h120)) begin
            miscompares++;
            $display("FAIL b2b_target: got valid=%b if_id=%h, want 1 %h",
                     if_id_valid_o, if_id_o, exp_entry(9'h120));
        end
    endtask

    task automatic test_stall_in_bubble();
        redirect_i = 1'b1; redirect_pc_i = 9'h0A0;
        step();
        redirect_i = 1'b0; stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (if_id_valid_o !== 1'b0 || if_id_o !== '0 || state_o !== BUBBLE ||
                imem_addr_o !== 9'h0A0 || imem_en_o !== 1'b0) begin
                miscompares++;
                $display("FAIL bubble_stall_%0d: got valid=%b if_id=%h state=%0d addr=%h en=%b, want 0 0 BUBBLE 0a0 0",
                         i, if_id_valid_o, if_id_o, state_o, imem_addr_o, imem_en_o);
            end
        end
        stall_i = 1'b0;
        step();
        vectors++;
        if (if_id_valid_o !== 1'b0 || state_o !== RUN) begin
            miscompares++;
            $display("FAIL bubble_release: got valid=%b state=%0d, want 0 RUN", if_id_valid_o, state_o);
        end
        step();
        vectors++;
        if (if_id_valid_o !== 1'b1 || if_id_o !== exp_entry(9'h0A0)) begin
            miscompares++;
            $display("FAIL bubble_target: got valid=%b if_id=%h, want 1 %h",
                     if_id_valid_o, if_id_o, exp_entry(9'h0A0));
        end
    endtask

    task automatic test_wrap();
        logic [8:0] cur [3];
        cur[0] = 9'h1F8; cur[1] = 9'h1FC; cur[2] = 9'h000;
        redirect_i = 1'b1; redirect_pc_i = 9'h1F8;
        step();
        redirect_i = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (if_id_valid_o !== 1'b1 || if_id_o !== exp_entry(cur[i])) begin
                miscompares++;
                $display("FAIL wrap_%h: got valid=%b if_id=%h, want 1 %h",
                         cur[i], if_id_valid_o, if_id_o, exp_entry(cur[i]));
            end
        end
        vectors++;
        if (if_id_o.pc_next !== 9'h004) begin
            miscompares++;
            $display("FAIL wrap_pc_next_000: got %h, want 004", if_id_o.pc_next);
        end
    endtask

    task automatic test_reset_mid_run();
        step();
        rst_n = 1'b0; stall_i = 1'b1; redirect_i = 1'b0;
        step();
        rst_n = 1'b1; stall_i = 1'b0;
        vectors++;
        if (if_id_valid_o !== 1'b0 || if_id_o !== '0 || imem_addr_o !== 9'h000 || state_o !== FILL) begin
            miscompares++;
            $display("FAIL midrun_reset: got valid=%b if_id=%h addr=%h state=%0d, want 0 0 000 FILL",
                     if_id_valid_o, if_id_o, imem_addr_o, state_o);
        end
        step();
        vectors++;
        if (if_id_valid_o !== 1'b0 || imem_addr_o !== 9'h004) begin
            miscompares++;
            $display("FAIL midrun_first_edge: got valid=%b addr=%h, want 0 004", if_id_valid_o, imem_addr_o);
        end
        step();
        vectors++;
        if (if_id_valid_o !== 1'b1 || if_id_o !== exp_entry(9'h000)) begin
            miscompares++;
            $display("FAIL midrun_refetch: got valid=%b if_id=%h, want 1 %h",
                     if_id_valid_o, if_id_o, exp_entry(9'h000));
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        imem_rdata_i = '0;
        test_reset();
        test_fill();
        test_stall();
        test_redirect(9'h043, 9'h040, 1'b0);
        test_redirect(9'h080, 9'h080, 1'b1);
        test_back_to_back();
        test_stall_in_bubble();
        test_wrap();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
